// File: rtl/ntt_bitrev_reorder_pkg.sv
// rtl/ntt_bitrev_reorder_pkg.sv - shared types and helpers for the NTT output reorder buffer
package ntt_bitrev_reorder_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_status_e;

  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_DRAIN = 1'b1;

  function automatic int bitrev_width(input int n_points);
    return $clog2(n_points);
  endfunction

endpackage

// File: rtl/bitreverse.sv
// rtl/bitreverse.sv - combinational bit-order reversal of a W-bit index
module bitreverse #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_in,
  output logic [W-1:0] o_out
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_out[i] = i_in[W-1-i];
  end

endmodule

// File: rtl/ntt_reorder_bank.sv
// rtl/ntt_reorder_bank.sv - simple dual-port N x LOGQ RAM with 1-cycle registered read
module ntt_reorder_bank #(
  parameter int LOGQ = 64,
  parameter int LOGN = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_en,
  input  logic [LOGN-1:0] i_wr_addr,
  input  logic [LOGQ-1:0] i_wr_data,
  input  logic            i_rd_en,
  input  logic [LOGN-1:0] i_rd_addr,
  output logic [LOGQ-1:0] o_rd_data
);

  logic [LOGQ-1:0] r_mem [0:(1<<LOGN)-1];
  logic [LOGQ-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register only moves on a read, so it doubles as the held output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ntt_bitrev_reorder.sv
// rtl/ntt_bitrev_reorder.sv - ping-pong bit-reversed to natural order reorder buffer; option NTT_REORDER_BYPASS_EN
module ntt_bitrev_reorder
  import ntt_bitrev_reorder_pkg::*;
#(
  parameter int LOGQ       = 64,
  parameter int LOGN       = 10,
  parameter int DELAY_BRAM = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [LOGQ-1:0] in_data,
  input  logic            intt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_data,
  output logic            out_last,
  output logic            overflow
);

  localparam int N  = 1 << LOGN;
  localparam int AW = bitrev_width(N);
  localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

  if (DELAY_BRAM != 1) begin : g_bad_delay
    $error("ntt_bitrev_reorder supports only DELAY_BRAM == 1");
  end

  bank_status_e    r_status [2];
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [AW-1:0]   r_wr_cnt;
  logic [AW-1:0]   r_rd_cnt;
  logic [0:0]      r_state;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_out_sel;
  logic            r_overflow;

  logic            w_wr_open;
  logic            w_wr_en;
  logic            w_rd_src;
  logic            w_issue;
  logic            w_rd_last;
  logic [AW-1:0]   w_rd_cnt_rev;
  logic [AW-1:0]   w_rd_addr;
  logic [LOGQ-1:0] w_bank_rd [2];

  assign w_wr_open = (r_status[r_wr_bank] == BANK_EMPTY) || (r_status[r_wr_bank] == BANK_FILLING);
  assign w_wr_en   = in_valid && w_wr_open;

  // Idle with a full bank may issue straight away, giving the k+1 first read.
  assign w_rd_src  = (r_state == RD_DRAIN) || (r_status[r_rd_bank] == BANK_FULL);
  assign w_issue   = w_rd_src && (!r_out_valid || out_ready);
  assign w_rd_last = w_issue && (r_rd_cnt == CNT_LAST);

  bitreverse #(.W(AW)) u_bitrev (
    .i_in  (r_rd_cnt),
    .o_out (w_rd_cnt_rev)
  );

`ifdef NTT_REORDER_BYPASS_EN
  logic r_mode [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode[0] <= 1'b0;
      r_mode[1] <= 1'b0;
    end else if (w_wr_en && (r_wr_cnt == '0)) begin
      r_mode[r_wr_bank] <= intt;
    end
  end

  assign w_rd_addr = r_mode[r_rd_bank] ? r_rd_cnt : w_rd_cnt_rev;
`else
  logic w_unused_intt;
  assign w_unused_intt = intt;
  assign w_rd_addr     = w_rd_cnt_rev;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ntt_reorder_bank #(.LOGQ(LOGQ), .LOGN(AW)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en && (r_wr_bank == 1'(b))),
      .i_wr_addr (r_wr_cnt),
      .i_wr_data (in_data),
      .i_rd_en   (w_issue && (r_rd_bank == 1'(b))),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_bank_rd[b])
    );
  end

  // Write and read sides only ever touch banks in disjoint status sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status[0] <= BANK_EMPTY;
      r_status[1] <= BANK_EMPTY;
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (r_wr_cnt == '0) begin
          r_status[r_wr_bank] <= BANK_FILLING;
        end
        if (r_wr_cnt == CNT_LAST) begin
          r_status[r_wr_bank] <= BANK_FULL;
          r_wr_bank           <= ~r_wr_bank;
          r_wr_cnt            <= '0;
        end else begin
          r_wr_cnt <= r_wr_cnt + AW'(1);
        end
      end else if (in_valid) begin
        r_overflow <= 1'b1;
      end
      if ((r_state == RD_IDLE) && (r_status[r_rd_bank] == BANK_FULL)) begin
        r_status[r_rd_bank] <= BANK_DRAINING;
      end
      if (w_rd_last) begin
        r_status[r_rd_bank] <= BANK_EMPTY;
        if (r_status[~r_rd_bank] == BANK_FULL) begin
          r_status[~r_rd_bank] <= BANK_DRAINING;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RD_IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_sel   <= 1'b0;
    end else if (w_issue) begin
      r_out_valid <= 1'b1;
      r_out_last  <= (r_rd_cnt == CNT_LAST);
      r_out_sel   <= r_rd_bank;
      if (r_rd_cnt == CNT_LAST) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= ~r_rd_bank;
        r_state   <= (r_status[~r_rd_bank] == BANK_FULL) ? RD_DRAIN : RD_IDLE;
      end else begin
        r_rd_cnt <= r_rd_cnt + AW'(1);
        r_state  <= RD_DRAIN;
      end
    end else begin
      if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if ((r_state == RD_IDLE) && (r_status[r_rd_bank] == BANK_FULL)) begin
        r_state <= RD_DRAIN;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = w_bank_rd[r_out_sel];
  assign overflow  = r_overflow;

endmodule
